// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Runs one 1-bit full adder over WIDTH-bit operands, one bit per enabled
// step, LSB first. The carry is held in a register between steps.
// Subtraction is done as A + ~B + 1.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high
//   step_en    advance enable while in ADD (tie high for full speed)
//   start      operation request, level-sampled, accepted only in IDLE
//   sub        0 = A+B, 1 = A-B, captured with the operands in LOAD
//   op_a/op_b  operands, captured in LOAD
//   clear_ovf  clears ovf_latch (a set in the same cycle wins)
//   busy       high in LOAD and ADD
//   done       one-cycle pulse in DONE
//   sum        result, updated only on DONE entry
//   carry_out  final carry, updated with sum
//   ovf_latch  sticky unsigned overflow / borrow flag
//   bit_idx    number of bits processed in the current operation
//   step_bit   sum bit produced by the most recent step
module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step_en,
  input  logic                     start,
  input  logic                     sub,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  input  logic                     clear_ovf,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         sum,
  output logic                     carry_out,
  output logic                     ovf_latch,
  output logic [$clog2(WIDTH):0]   bit_idx,
  output logic                     step_bit
);

  localparam int IDX_W = $clog2(WIDTH) + 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, acc_reg;
  logic             carry_reg, sub_reg;

  logic             step, last_step;
  logic             s_bit, c_next;
  logic [WIDTH-1:0] acc_next;
  logic             ovf_set;

  // One full-adder slice on the current LSBs.
  assign s_bit    = a_sh_reg[0] ^ b_sh_reg[0] ^ carry_reg;
  assign c_next   = (a_sh_reg[0] & b_sh_reg[0]) | (a_sh_reg[0] & carry_reg) |
                    (b_sh_reg[0] & carry_reg);
  assign acc_next = {s_bit, acc_reg[WIDTH-1:1]};

  // Add: carry out means overflow. Subtract: missing carry means borrow.
  assign ovf_set  = last_step & (sub_reg ? ~c_next : c_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    step       = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        state_next = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (step_en) begin
          step = 1'b1;
          if (bit_idx == LAST_IDX) begin
            last_step  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      bit_idx   <= '0;
      step_bit  <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      ovf_latch <= 1'b0;
    end else begin
      if (state_reg == LOAD) begin
        a_sh_reg  <= op_a;
        b_sh_reg  <= sub ? ~op_b : op_b;
        carry_reg <= sub;
        sub_reg   <= sub;
        acc_reg   <= '0;
        bit_idx   <= '0;
      end
      if (step) begin
        a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
        b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
        carry_reg <= c_next;
        acc_reg   <= acc_next;
        step_bit  <= s_bit;
        bit_idx   <= bit_idx + idx_t'(1);
      end
      // The result is published on the same edge as the final step.
      if (last_step) begin
        sum       <= acc_next;
        carry_out <= c_next;
      end
      if (ovf_set) begin
        ovf_latch <= 1'b1;
      end else if (clear_ovf) begin
        ovf_latch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int WIDTH = 4;
  localparam int IW    = $clog2(WIDTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             step_en = 1'b1;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             clear_ovf = 1'b0;
  logic             busy, done, carry_out, ovf_latch, step_bit;
  logic [WIDTH-1:0] sum;
  logic [IW-1:0]    bit_idx;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .start(start), .sub(sub),
    .op_a(op_a), .op_b(op_b), .clear_ovf(clear_ovf), .busy(busy), .done(done),
    .sum(sum), .carry_out(carry_out), .ovf_latch(ovf_latch), .bit_idx(bit_idx),
    .step_bit(step_bit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic model_ovf = 1'b0;
  logic obs_bit[$];
  int   obs_idx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result from plain integer arithmetic, pushed when the op is requested.
  task automatic push_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;
    exp_t             e;
    bx   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, s};
    e.a    = a;
    e.b    = b;
    e.s    = s;
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    if (s ? !e.cout : e.cout) model_ovf = 1'b1;
    e.ovf  = model_ovf;
    exp_q.push_back(e);
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    push_op(a, b, s);
  endtask

  // Waits for done (bounded). Scrambles operands two cycles after the request
  // so every operation also shows that late operand changes are ignored.
  task automatic wait_done(input bit keep_start, input bit gate, input int clear_at,
                           output int lat, output int busy_n, output bit ok);
    bit prev_step;
    prev_step = 1'b0;
    lat = 0;
    busy_n = 0;
    ok = 1'b0;
    obs_bit.delete();
    obs_idx.delete();
    while (lat < 40) begin
      tick();
      lat++;
      if (prev_step) begin
        obs_bit.push_back(step_bit);
        obs_idx.push_back(int'(bit_idx));
      end
      if (!keep_start) start = 1'b0;
      if (lat == 2) begin
        op_a = WIDTH'($urandom());
        op_b = WIDTH'($urandom());
        sub  = 1'($urandom());
      end
      clear_ovf = (lat == clear_at);
      step_en   = gate ? (lat % 2 == 0) : 1'b1;
      prev_step = busy && (lat >= 2) && step_en;
      if (busy) busy_n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    clear_ovf = 1'b0;
    step_en   = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got %0d want 0", sum); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", carry_out); end
    checks++; if (ovf_latch !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_latch); end
    checks++; if (bit_idx !== '0) begin errors++; $display("FAIL reset_bit_idx got %0d want 0", bit_idx); end
    checks++; if (step_bit !== 1'b0) begin errors++; $display("FAIL reset_step_bit got %b want 0", step_bit); end
    reset = 1'b0;
    tick();
    $display("reset: busy=%b sum=%0d ovf=%b", busy, sum, ovf_latch);
  endtask

  task automatic run_and_compare(input string name, input int exp_lat, input int exp_busy,
                                 input bit gate, input int clear_at, input bit keep_start);
    int   lat, busy_n;
    bit   ok;
    exp_t e;
    wait_done(keep_start, gate, clear_at, lat, busy_n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout got no done after %0d cycles want done", name, lat);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      $display("%s: a=%0d b=%0d sub=%0d -> sum=%0d cout=%b ovf=%b lat=%0d (want %0d/%b/%b)",
               name, e.a, e.b, e.s, sum, carry_out, ovf_latch, lat, e.sum, e.cout, e.ovf);
      checks++; if (sum !== e.sum) begin errors++; $display("FAIL %s_sum got %0d want %0d", name, sum, e.sum); end
      checks++; if (carry_out !== e.cout) begin errors++; $display("FAIL %s_cout got %b want %b", name, carry_out, e.cout); end
      checks++; if (ovf_latch !== e.ovf) begin errors++; $display("FAIL %s_ovf got %b want %b", name, ovf_latch, e.ovf); end
    end
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
    checks++; if (busy_n !== exp_busy) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_n, exp_busy); end
  endtask

  task automatic do_clear();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    model_ovf = 1'b0;
    tick();
    checks++; if (ovf_latch !== 1'b0) begin errors++; $display("FAIL clear_ovf got %b want 0", ovf_latch); end
  endtask

  task automatic test_add_basic();
    start_op(4'd5, 4'd6, 1'b0);
    run_and_compare("add_5_6", WIDTH + 2, WIDTH + 1, 1'b0, -1, 1'b0);
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_overflow();
    start_op(4'd9, 4'd8, 1'b0);
    run_and_compare("add_9_8", WIDTH + 2, WIDTH + 1, 1'b0, -1, 1'b0);
    tick();
    start_op(4'd2, 4'd3, 1'b0);
    run_and_compare("add_2_3", WIDTH + 2, WIDTH + 1, 1'b0, -1, 1'b0);
    tick();
    do_clear();
  endtask

  task automatic test_sub();
    start_op(4'd7, 4'd3, 1'b1);
    run_and_compare("sub_7_3", WIDTH + 2, WIDTH + 1, 1'b0, -1, 1'b0);
    tick();
    start_op(4'd3, 4'd7, 1'b1);
    run_and_compare("sub_3_7", WIDTH + 2, WIDTH + 1, 1'b0, -1, 1'b0);
    tick();
    do_clear();
  endtask

  task automatic test_step_gating();
    exp_t e;
    start_op(4'd5, 4'd6, 1'b0);
    e = exp_q[0];
    run_and_compare("gated_5_6", 2 * WIDTH + 1, 2 * WIDTH, 1'b1, -1, 1'b0);
    checks++;
    if (obs_bit.size() !== WIDTH) begin
      errors++;
      $display("FAIL gated_step_count got %0d want %0d", obs_bit.size(), WIDTH);
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        $display("gated step %0d: step_bit=%b bit_idx=%0d", i, obs_bit[i], obs_idx[i]);
        checks++; if (obs_bit[i] !== e.sum[i]) begin errors++; $display("FAIL gated_step_bit%0d got %b want %b", i, obs_bit[i], e.sum[i]); end
        checks++; if (obs_idx[i] !== i + 1) begin errors++; $display("FAIL gated_bit_idx%0d got %0d want %0d", i, obs_idx[i], i + 1); end
      end
    end
    tick();
  endtask

  task automatic test_start_held();
    int extra;
    start_op(4'd4, 4'd3, 1'b0);
    run_and_compare("held_4_3", WIDTH + 2, WIDTH + 1, 1'b0, -1, 1'b1);
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_visit got busy %b want 0", busy); end
    // start is still high here, so this IDLE cycle launches exactly one new op
    // using whatever operands are on the pins now.
    push_op(op_a, op_b, sub);
    run_and_compare("held_second", WIDTH + 2, WIDTH + 1, 1'b0, -1, 1'b0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL held_no_queue got %0d active cycles want 0", extra); end
  endtask

  task automatic test_clear_set_same();
    start_op(4'd9, 4'd8, 1'b0);
    run_and_compare("clrset_9_8", WIDTH + 2, WIDTH + 1, 1'b0, WIDTH + 1, 1'b0);
    tick();
    checks++; if (ovf_latch !== 1'b1) begin errors++; $display("FAIL clrset_hold got %b want 1", ovf_latch); end
  endtask

  task automatic test_reset_mid();
    int dones;
    op_a  = 4'd9;
    op_b  = 4'd8;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_ovf = 1'b0;
    $display("reset_mid: busy=%b done=%b sum=%0d ovf=%b", busy, done, sum, ovf_latch);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (sum !== '0) begin errors++; $display("FAIL rmid_sum got %0d want 0", sum); end
    checks++; if (ovf_latch !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b want 0", ovf_latch); end
    checks++; if (bit_idx !== '0) begin errors++; $display("FAIL rmid_bit_idx got %0d want 0", bit_idx); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      tick();
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rmid_done got %0d pulses want 0", dones); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_basic();
    test_overflow();
    test_sub();
    test_step_gating();
    test_start_held();
    do_clear();
    test_clear_set_same();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Sequencer that time-shares a single 1-bit full adder across WIDTH-bit operands, one bit per enabled step, LSB first. It captures operands on a start request, runs the carry chain through a registered carry, and presents the sum, carry-out and a sticky overflow flag to the LED/PMOD demo top level. A step-enable input lets the top level run the sequence at full clock rate or slow it to a visible rate with the existing half-second pulse.

## Interface
- WIDTH, 4: operand and sum width in bits, 2..16.
- clk  in  1  system clock (12 MHz board clock).
- reset  in  1  synchronous, active-high; clock clk.
- step_en  in  1  advance enable for ADD state; tie to 1 for full speed.
- start  in  1  operation request; level-sampled, accepted only in IDLE.
- sub  in  1  0 = A+B, 1 = A−B; sampled with operands.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- clear_ovf  in  1  clears ovf_latch.
- busy  out  1  high in LOAD and ADD.
- done  out  1  one-cycle pulse in DONE state.
- sum  out  WIDTH  result, registered, held until next completion.
- carry_out  out  1  final carry of last operation, held with sum.
- ovf_latch  out  1  sticky overflow/borrow flag.
- bit_idx  out  clog2(WIDTH)+1  bits processed so far in the current operation.
- step_bit  out  1  sum bit produced on the most recent step, for LED display.

## Operation
- States: IDLE, LOAD, ADD, DONE. Reset → IDLE.
- IDLE: start=1 → LOAD; otherwise stay.
- LOAD (1 cycle): A_sh←op_a; B_sh←(sub ? ~op_b : op_b); carry←sub; acc←0; bit_idx←0 → ADD.
- ADD: on each cycle with step_en=1: s=A_sh[0]^B_sh[0]^carry; carry←majority(A_sh[0],B_sh[0],carry); A_sh, B_sh shift right by 1; acc shifts right with s into MSB; step_bit←s; bit_idx+1. step_en=0: all state held.
- After the WIDTH-th step → DONE. sum←final acc; carry_out←final carry; same edge.
- DONE (1 cycle): done=1 → IDLE.
- Arithmetic is modulo 2^WIDTH. Add: carry_out=1 means unsigned overflow. Sub: carry_out=1 means no borrow (A≥B), 0 means borrow.
- ovf_latch set on DONE entry when (sub=0 and carry_out=1) or (sub=1 and carry_out=0); cleared by clear_ovf; set wins when both occur in the same cycle; never cleared by a new operation.
- start outside IDLE (LOAD, ADD, DONE) ignored, no queuing. Changes to op_a/op_b/sub after LOAD have no effect.
- reset mid-operation: immediate return to IDLE, in-flight result discarded.
- Reset values: busy 0, done 0, sum 0, carry_out 0, ovf_latch 0, bit_idx 0, step_bit 0.

## Timing
- start=1 in IDLE at cycle t: LOAD at t+1, ADD from t+2.
- step_en held 1: steps at t+2..t+WIDTH+1, DONE (done=1, sum valid) at t+WIDTH+2, IDLE at t+WIDTH+3; earliest next start accepted at t+WIDTH+3.
- Each step_en=0 cycle in ADD delays DONE by one cycle.
- busy=1 from t+1 through last ADD cycle; busy=0 in DONE.
- sum/carry_out change only on DONE entry or reset.

## Test plan
- WIDTH=4, step_en=1, A=5, B=6, sub=0, start pulse at t → done at t+6, sum=11, carry_out=0, ovf_latch=0, busy high t+1..t+5.
- A=9, B=8, sub=0 → sum=1, carry_out=1, ovf_latch=1; next op 2+3 → sum=5, ovf_latch stays 1; clear_ovf pulse → 0.
- Subtract: A=7, B=3, sub=1 → sum=4, carry_out=1, ovf unchanged; A=3, B=7, sub=1 → sum=12, carry_out=0, ovf_latch=1.
- step_en alternating 1/0 starting at t+2 with 5+6 → done at t+9, sum=11; step_bit sequence 1,1,0,1; bit_idx 1,2,3,4.
- start held high through whole op and second start asserted mid-ADD → exactly one operation per IDLE visit; operands changed after LOAD don't affect sum.
- reset asserted at third ADD step of 9+8 → next cycle IDLE, busy 0, sum 0, ovf_latch 0, no done pulse; clear_ovf and set on same DONE cycle → ovf_latch=1.
